// File: rtl/pipelined_multiply_pkg.sv
// Shared widths, pipeline depth limits and the per-operation mode bundle
// for the pipelined multiply-accumulate block.
package pipelined_multiply_pkg;

  localparam int DEF_A_WIDTH     = 36;
  localparam int DEF_B_WIDTH     = 36;
  localparam int DEF_Y_WIDTH     = DEF_A_WIDTH + DEF_B_WIDTH;
  localparam int DEF_PIPE_STAGES = 3;
  localparam int PIPE_MIN        = 1;
  localparam int PIPE_MAX        = 8;

  typedef struct packed {
    logic sgn;
    logic acc;
  } mode_t;

  localparam int MODE_W = $bits(mode_t);

  function automatic logic pipe_ok(input int stages);
    return (stages >= PIPE_MIN) && (stages <= PIPE_MAX);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One valid/data register slice of the multiply pipeline; hold freezes
// both the valid bit and the payload.
module mult_pipe_stage
  import pipelined_multiply_pkg::*;
#(
  parameter int W = DEF_Y_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipelined_multiply.sv
// Signed/unsigned multiplier with optional accumulate into the last
// delivered result, valid/ready on both sides and a global stall.
module pipelined_multiply
  import pipelined_multiply_pkg::*;
#(
  parameter int A_WIDTH     = DEF_A_WIDTH,
  parameter int B_WIDTH     = DEF_B_WIDTH,
  parameter int Y_WIDTH     = A_WIDTH + B_WIDTH,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               in_signed,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] out
);

  localparam int DW = Y_WIDTH + 1;

  typedef struct packed {
    logic               acc;
    logic [Y_WIDTH-1:0] prod;
  } beat_t;

  if (!pipe_ok(PIPE_STAGES)) begin : g_bad_pipe
    $error("PIPE_STAGES out of range");
  end

  logic               stall;
  mode_t              mode;
  logic [Y_WIDTH-1:0] a_ext;
  logic [Y_WIDTH-1:0] b_ext;
  beat_t              head;

  logic               st_valid [PIPE_STAGES];
  beat_t              st_data  [PIPE_STAGES];

  logic               out_valid_q;
  logic               out_valid_d;
  logic [Y_WIDTH-1:0] out_q;
  logic [Y_WIDTH-1:0] out_d;
  logic [Y_WIDTH-1:0] acc_q;
  logic [Y_WIDTH-1:0] acc_d;
  logic               xfer;
  beat_t              tail;
  logic               tail_valid;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign xfer     = out_valid_q && out_ready;

  assign mode.sgn = in_signed;
  assign mode.acc = in_acc;

  // Sign is consumed here; only the accumulate flag rides with the product.
  always_comb begin
    a_ext = {{(Y_WIDTH-A_WIDTH){1'b0}}, a};
    b_ext = {{(Y_WIDTH-B_WIDTH){1'b0}}, b};
    if (mode.sgn) begin
      a_ext = {{(Y_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
      b_ext = {{(Y_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
    end
    head.acc  = mode.acc;
    head.prod = a_ext * b_ext;
  end

  assign st_valid[0] = in_valid;
  assign st_data[0]  = head;

  for (genvar i = 1; i < PIPE_STAGES; i++) begin : g_stage
    mult_pipe_stage #(
      .W (DW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (stall),
      .in_valid  (st_valid[i-1]),
      .in_data   (st_data[i-1]),
      .out_valid (st_valid[i]),
      .out_data  (st_data[i])
    );
  end

  assign tail       = st_data[PIPE_STAGES-1];
  assign tail_valid = st_valid[PIPE_STAGES-1];

  // acc_d already holds the result leaving this cycle, so a back-to-back
  // accumulate sees it without a bubble.
  always_comb begin
    acc_d       = xfer ? out_q : acc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (!stall) begin
      out_valid_d = tail_valid;
      if (tail_valid) begin
        out_d = tail.acc ? acc_d + tail.prod : tail.prod;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_pipelined_multiply.sv
// Directed and random checks of pipelined_multiply at depths 3, 1 and 8
// against an in-order scoreboard of expected results and latencies.
module tb_pipelined_multiply;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        sg   [3];
  logic        ac   [3];
  logic [7:0]  ia   [3];
  logic [7:0]  ib   [3];
  logic [15:0] yo   [3];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int          lat [3];
  logic [15:0] ey  [3][256];
  int          ec  [3][256];
  int          es  [3][256];
  int          hd  [3];
  int          tl  [3];
  int          stc [3];
  int          rx  [3];
  logic [15:0] macc[3];

  always #5 clk = ~clk;

  pipelined_multiply #(
    .A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(16), .PIPE_STAGES(3)
  ) u_p3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ia[0]), .b(ib[0]),
    .in_signed(sg[0]), .in_acc(ac[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out(yo[0])
  );

  pipelined_multiply #(
    .A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(16), .PIPE_STAGES(1)
  ) u_p1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ia[1]), .b(ib[1]),
    .in_signed(sg[1]), .in_acc(ac[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out(yo[1])
  );

  pipelined_multiply #(
    .A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(16), .PIPE_STAGES(8)
  ) u_p8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ia[2]), .b(ib[2]),
    .in_signed(sg[2]), .in_acc(ac[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out(yo[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp_v);
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  // Scoreboard: results are modelled in acceptance order, each one
  // accumulating onto the previous expected result.
  always @(negedge clk) begin
    logic [15:0] nxt;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        hd[d]   = 0;
        tl[d]   = 0;
        macc[d] = '0;
      end else begin
        if (ov[d] && ordy[d]) begin
          chk("sb_nonempty", 32'(tl[d] != hd[d]), 32'd1);
          if (tl[d] != hd[d]) begin
            chk("out_val", 32'(yo[d]), 32'(ey[d][hd[d] % 256]));
            chk("latency", 32'(cyc - ec[d][hd[d] % 256]),
                32'(lat[d] + stc[d] - es[d][hd[d] % 256]));
            hd[d]++;
          end
          rx[d]++;
        end
        if (iv[d] && ir[d]) begin
          nxt = ref_prod(ia[d], ib[d], sg[d]);
          if (ac[d]) nxt = macc[d] + nxt;
          macc[d]           = nxt;
          ey[d][tl[d] % 256] = nxt;
          ec[d][tl[d] % 256] = cyc;
          es[d][tl[d] % 256] = stc[d];
          tl[d]++;
        end
        if (ov[d] && !ordy[d]) stc[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input logic [7:0] x,
                     input logic [7:0] y, input logic s,
                     input logic c);
    iv[d] = 1'b1;
    ia[d] = x;
    ib[d] = y;
    sg[d] = s;
    ac[d] = c;
  endtask

  task automatic idle(input int d);
    iv[d] = 1'b0;
  endtask

  initial begin
    int  k;
    int  rx0;
    logic took;

    lat[0] = 3;
    lat[1] = 1;
    lat[2] = 8;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 0; ordy[d] = 1; sg[d] = 0; ac[d] = 0;
      ia[d] = 0; ib[d] = 0;
      hd[d] = 0; tl[d] = 0; stc[d] = 0; rx[d] = 0;
      macc[d] = '0;
    end

    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", 32'(ov[d]), 0);
      chk("rst_in_ready", 32'(ir[d]), 1);
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("post_rst_out_valid", 32'(ov[d]), 0);
      chk("post_rst_in_ready", 32'(ir[d]), 1);
    end

    // Unsigned 255*255, exactly three cycles
    put(0, 8'd255, 8'd255, 1'b0, 1'b0);
    tick();
    idle(0);
    chk("u255_c1_valid", 32'(ov[0]), 0);
    tick();
    chk("u255_c2_valid", 32'(ov[0]), 0);
    tick();
    chk("u255_c3_valid", 32'(ov[0]), 1);
    chk("u255_c3_out", 32'(yo[0]), 32'd65025);
    repeat (2) tick();

    // Signed then unsigned on the same operands
    put(0, 8'hFF, 8'h02, 1'b1, 1'b0);
    tick();
    put(0, 8'hFF, 8'h02, 1'b0, 1'b0);
    tick();
    idle(0);
    tick();
    chk("signed_out", 32'(yo[0]), 32'h0000FFFE);
    tick();
    chk("unsigned_out", 32'(yo[0]), 32'h000001FE);
    repeat (2) tick();

    // Back-to-back accumulate chain
    for (int i = 0; i < 7; i++) begin
      if (i < 4) put(0, 8'd3, 8'd4, 1'b0, i != 0);
      else idle(0);
      if (i >= 3) begin
        chk("chain_valid", 32'(ov[0]), 1);
        chk("chain_out", 32'(yo[0]), 32'(12 * (i - 2)));
      end
      tick();
    end
    repeat (2) tick();

    // 16-bit wrap on accumulate
    put(0, 8'hF0, 8'h01, 1'b1, 1'b0);
    tick();
    put(0, 8'h20, 8'h01, 1'b0, 1'b1);
    tick();
    idle(0);
    tick();
    chk("wrap_base", 32'(yo[0]), 32'h0000FFF0);
    tick();
    chk("wrap_out", 32'(yo[0]), 32'h00000010);
    repeat (2) tick();

    // Backpressure mid-stream; ops are held until accepted
    k   = 0;
    rx0 = rx[0];
    for (int c = 0; c < 40; c++) begin
      ordy[0] = !(c >= 4 && c < 9);
      if (k < 10)
        put(0, 8'(k * 7 + 1), 8'(k + 3), k[0], k > 0);
      else
        idle(0);
      @(negedge clk);
      took = iv[0] && ir[0];
      if (c >= 4 && c < 9) begin
        chk("bp_out_valid", 32'(ov[0]), 1);
        chk("bp_in_ready", 32'(ir[0]), 0);
      end
      @(posedge clk);
      #1;
      if (took) k++;
    end
    ordy[0] = 1'b1;
    chk("bp_sent", 32'(k), 32'd10);
    chk("bp_received", 32'(rx[0] - rx0), 32'd10);

    // Reset with two ops in flight after acc = 100
    put(0, 8'd10, 8'd10, 1'b0, 1'b0);
    tick();
    idle(0);
    repeat (4) tick();
    put(0, 8'd5, 8'd5, 1'b0, 1'b1);
    tick();
    put(0, 8'd6, 8'd6, 1'b0, 1'b1);
    tick();
    idle(0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", 32'(ov[0]), 0);
      tick();
    end
    put(0, 8'd2, 8'd3, 1'b0, 1'b1);
    tick();
    idle(0);
    repeat (2) tick();
    chk("post_flush_valid", 32'(ov[0]), 1);
    chk("post_flush_out", 32'(yo[0]), 32'd6);
    repeat (2) tick();

    // Random sweep on all three depths with bubbles and stalls
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = $urandom_range(0, 3) != 0;
        ia[d]   = 8'($urandom);
        ib[d]   = 8'($urandom);
        sg[d]   = 1'($urandom);
        ac[d]   = 1'($urandom);
        ordy[d] = $urandom_range(0, 9) < 7;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      idle(d);
      ordy[d] = 1'b1;
    end
    repeat (20) tick();
    for (int d = 0; d < 3; d++) begin
      chk("drain_empty", 32'(tl[d] - hd[d]), 0);
      chk("sweep_active", 32'(rx[d] > 50), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_multiply.md
PIPELINED_MULTIPLY -- requirements
Module: pipelined_multiply

Interface
REQ-001 Parameter A_WIDTH, default 36: width of operand a (1..64).
REQ-002 Parameter B_WIDTH, default 36: width of operand b (1..64).
REQ-003 Parameter Y_WIDTH, default A_WIDTH+B_WIDTH: result and accumulator width (>= A_WIDTH+B_WIDTH).
REQ-004 Parameter PIPE_STAGES, default 3: input-to-output latency in cycles (1..8).
REQ-005 clk  input  1: sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1: reset, synchronous, active-low.
REQ-007 in_valid  input  1: a, b, in_signed, in_acc hold a valid operation.
REQ-008 in_ready  output  1: block accepts an operation this cycle.
REQ-009 a  input  A_WIDTH: multiplicand.
REQ-010 b  input  B_WIDTH: multiplier.
REQ-011 in_signed  input  1: 1 = two's-complement operands, 0 = unsigned.
REQ-012 in_acc  input  1: 1 = add product to previous delivered result, 0 = plain product.
REQ-013 out_valid  output  1: out holds a valid result.
REQ-014 out_ready  input  1: consumer takes result this cycle.
REQ-015 out  output  Y_WIDTH: result.

Function
REQ-016 Operation transfers in when in_valid && in_ready; result transfers out when out_valid && out_ready.
REQ-017 Unstalled, a transferred operation appears on out exactly PIPE_STAGES cycles later with out_valid=1.
REQ-018 Stall = out_valid && !out_ready; in_ready = !stall; during stall every pipeline stage, including out, holds its value.
REQ-019 Bubbles (in_valid=0) propagate as invalid stages; results are never reordered, duplicated or dropped.
REQ-020 Signed mode: a and b sign-extended to Y_WIDTH before multiplication; unsigned: zero-extended.
REQ-021 Product computed modulo 2^Y_WIDTH.
REQ-022 Accumulator register acc (Y_WIDTH) updates only at an output transfer, to that transfer's out value.
REQ-023 Final stage: out = in_acc ? acc + product : product, modulo 2^Y_WIDTH (wraps, no saturation, no overflow flag).
REQ-024 Back-to-back accumulate operations chain correctly: final-stage addition uses acc including the result transferred on the immediately preceding cycle (forward when needed).
REQ-025 in_signed/in_acc travel with their operands through the pipeline; mode may change every operation.
REQ-026 out_valid shall not depend combinationally on out_ready; in_ready depends combinationally only on out_valid and out_ready.
REQ-027 out is don't-care while out_valid=0; bench checks out only on transfers.

Reset
REQ-028 With rst_n=0 at a rising edge: all stage valid bits, out_valid, out and acc become 0.
REQ-029 in_ready = 1 during and immediately after reset (out_valid=0).
REQ-030 Reset mid-operation discards all in-flight operations; none emerge afterwards.
REQ-031 Operations presented while rst_n=0 are not accepted.

Structure
REQ-032 Shared package pipelined_multiply_pkg holds default widths, PIPE_STAGES limits and a mode struct/typedef {signed, acc}.
REQ-033 One sub-module mult_pipe_stage: single valid/data register stage with hold enable, instantiated PIPE_STAGES-1 times; final stage (accumulate) stays in top.
REQ-034 No vendor primitives; product expressed as behavioural multiply for synthesis mapping to the hard multiplier.

Verification
REQ-035 Unsigned, A=B=8, Y=16, PIPE=3: a=255,b=255, in_acc=0 -> out=65025 exactly 3 cycles later.
REQ-036 Signed, A=B=8, Y=16: a=0xFF,b=0x02 -> out=0xFFFE; same operands unsigned next cycle -> out=0x01FE on the following cycle.
REQ-037 Accumulate chain, 4 back-to-back ops a=3,b=4 with in_acc=0,1,1,1 -> outputs 12,24,36,48 on consecutive cycles; 16-bit wrap: acc=0xFFF0 plus 0x20 -> 0x0010.
REQ-038 Backpressure: stream 10 ops, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, all 10 results in order, none lost or repeated.
REQ-039 Reset with 2 ops in flight and acc=100 -> no out_valid after reset; next in_acc=1 op a=2,b=3 -> out=6.
REQ-040 PIPE_STAGES=1 and 8 sweeps with random stall/bubble patterns -> results match reference model, latency equals PIPE_STAGES when unstalled.
